// File: rtl/alu_muldiv_seq_if.sv
// Request/result bundle between the execute stage and the mul/div sequencer.
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_by_zero;

    modport master (
        output start, alu_ctrl, op_a, op_b,
        input  stall, busy, done, result_hi, result_lo, div_by_zero
    );

    modport slave (
        input  start, alu_ctrl, op_a, op_b,
        output stall, busy, done, result_hi, result_lo, div_by_zero
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiply / restoring divide sequencer; stalls the pipeline while busy.
// Define MULDIV_SIGNED_EN for two's-complement operands with sign fix-up in FIX.
module alu_muldiv_seq #(
    parameter int WIDTH = 16
) (
    input logic             clk,
    input logic             rst,
    alu_muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             bz_q, bz_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic             dbz_q, dbz_d;

    logic             code_ok;
    logic             accept;
    logic             busy;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rsh;
    logic             ge;
    logic [WIDTH-1:0] rem_sub;
    logic [2*WIDTH-1:0] prod;
    logic             neg;

    assign code_ok = (bus.alu_ctrl == 4'b0001) || (bus.alu_ctrl == 4'b0010);
    assign busy    = (state_q == RUN) || (state_q == FIX);
    assign accept  = bus.start && code_ok
                   && ((state_q == IDLE) || (state_q == DONE));

`ifdef MULDIV_SIGNED_EN
    assign sign_a = bus.op_a[WIDTH-1];
    assign sign_b = bus.op_b[WIDTH-1];
    assign mag_a  = sign_a ? -bus.op_a : bus.op_a;
    assign mag_b  = sign_b ? -bus.op_b : bus.op_b;
`else
    assign sign_a = 1'b0;
    assign sign_b = 1'b0;
    assign mag_a  = bus.op_a;
    assign mag_b  = bus.op_b;
`endif

    // {sum, lo_q} is the 2*WIDTH+1 bit accumulator before the right shift
    assign sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign rsh     = {hi_q, lo_q[WIDTH-1]};
    assign ge      = rsh >= {1'b0, m_q};
    assign rem_sub = rsh[WIDTH-1:0] - m_q;
    assign neg     = sa_q ^ sb_q;
    assign prod    = neg ? -{hi_q, lo_q} : {hi_q, lo_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bz_d     = bz_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dbz_d    = dbz_q;
        unique case (state_q)
            IDLE: ;
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    hi_d = ge ? rem_sub : rsh[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], ge};
                end else begin
                    hi_d = sum[WIDTH:1];
                    lo_d = {sum[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    // a zero divisor leaves the quotient at all ones
                    res_lo_d = (neg && !bz_q) ? -lo_q : lo_q;
                    res_hi_d = sa_q ? -hi_q : hi_q;
                    dbz_d    = bz_q;
                end else begin
                    res_hi_d = prod[2*WIDTH-1:WIDTH];
                    res_lo_d = prod[WIDTH-1:0];
                    dbz_d    = 1'b0;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d  = RUN;
            cnt_d    = CW'(WIDTH);
            is_div_d = bus.alu_ctrl[1];
            m_d      = bus.alu_ctrl[1] ? mag_b : mag_a;
            lo_d     = bus.alu_ctrl[1] ? mag_a : mag_b;
            hi_d     = '0;
            sa_d     = sign_a;
            sb_d     = sign_b;
            bz_d     = (bus.op_b == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bz_q     <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bz_q     <= bz_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.stall       = busy | accept;
    assign bus.busy        = busy;
    assign bus.done        = (state_q == DONE);
    assign bus.result_hi   = res_hi_q;
    assign bus.result_lo   = res_lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq against an arithmetic reference.
// Honours MULDIV_SIGNED_EN the same way the design does.
module tb_alu_muldiv_seq;
    localparam int W = 16;
    localparam logic [3:0] MUL = 4'b0001;
    localparam logic [3:0] DIV = 4'b0010;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dbz;

    alu_muldiv_seq_if #(.WIDTH(W)) bus ();

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [3:0] ctrl,
                                  input logic [W-1:0] a, b,
                                  output logic [W-1:0] hi, lo,
                                  output logic dbz);
        longint x, y, p, q, r;
`ifdef MULDIV_SIGNED_EN
        x = longint'($signed(a));
        y = longint'($signed(b));
`else
        x = longint'(a);
        y = longint'(b);
`endif
        hi = '0;
        lo = '0;
        dbz = 1'b0;
        if (ctrl == MUL) begin
            p  = x * y;
            hi = p[31:16];
            lo = p[15:0];
        end else if (b == '0) begin
            lo  = '1;
            hi  = a;
            dbz = 1'b1;
        end else begin
            q  = x / y;
            r  = x % y;
            lo = q[15:0];
            hi = r[15:0];
        end
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    // Enters in an IDLE or DONE cycle, returns in the DONE cycle of this op.
    task automatic do_op(input logic [3:0] ctrl, input logic [W-1:0] a, b,
                         input bit poke);
        model(ctrl, a, b, exp_hi, exp_lo, exp_dbz);
        bus.start    = 1'b1;
        bus.alu_ctrl = ctrl;
        bus.op_a     = a;
        bus.op_b     = b;
        #1 check("stall_accept", bus.stall, 1'b1);
        tick();
        bus.start    = 1'b0;
        bus.alu_ctrl = 4'($urandom_range(0, 15));
        bus.op_a     = 16'($urandom);
        bus.op_b     = 16'($urandom);
        for (int c = 1; c <= W + 1; c++) begin
            check("busy_run", bus.busy, 1'b1);
            check("done_run", bus.done, 1'b0);
            check("stall_run", bus.stall, 1'b1);
            if (poke && c == 5) begin
                bus.start    = 1'b1;
                bus.alu_ctrl = (ctrl == MUL) ? DIV : MUL;
            end
            if (poke && c == 6) bus.start = 1'b0;
            tick();
        end
        check("done_pulse", bus.done, 1'b1);
        check("busy_done", bus.busy, 1'b0);
        check("stall_done", bus.stall, 1'b0);
        check("result_hi", bus.result_hi, exp_hi);
        check("result_lo", bus.result_lo, exp_lo);
        check("div_by_zero", bus.div_by_zero, exp_dbz);
    endtask

    task automatic bad_code();
        bus.start    = 1'b1;
        bus.alu_ctrl = 4'($urandom_range(3, 15));
        bus.op_a     = 16'($urandom);
        bus.op_b     = 16'($urandom);
        if ($urandom_range(0, 1) == 1) bus.alu_ctrl = 4'b0000;
        #1 check("stall_bad", bus.stall, 1'b0);
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check("busy_bad", bus.busy, 1'b0);
            check("done_bad", bus.done, 1'b0);
            check("hold_hi", bus.result_hi, exp_hi);
            check("hold_lo", bus.result_lo, exp_lo);
            check("hold_dbz", bus.div_by_zero, exp_dbz);
            tick();
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        exp_hi       = '0;
        exp_lo       = '0;
        exp_dbz      = 1'b0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.alu_ctrl = 4'b0000;
        bus.op_a     = '0;
        bus.op_b     = '0;
        tick();
        tick();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_stall", bus.stall, 1'b0);
        check("rst_hi", bus.result_hi, 16'h0000);
        check("rst_lo", bus.result_lo, 16'h0000);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        rst = 1'b0;
        tick();

        do_op(MUL, 16'h0003, 16'h0005, 1'b0);
        check("tp_mul_3x5", {bus.result_hi, bus.result_lo}, 32'h0000_000F);
        tick();
        do_op(MUL, 16'hFFFF, 16'hFFFF, 1'b0);
`ifndef MULDIV_SIGNED_EN
        check("tp_mul_ffff", {bus.result_hi, bus.result_lo}, 32'hFFFE_0001);
`endif
        tick();
        do_op(DIV, 16'd100, 16'd7, 1'b0);
        check("tp_div_100_7", {bus.result_hi, bus.result_lo}, {16'd2, 16'd14});
        do_op(DIV, 16'h1234, 16'h0000, 1'b0);
        check("tp_dbz", {bus.result_hi, bus.result_lo}, 32'h1234_FFFF);
        check("tp_dbz_flag", bus.div_by_zero, 1'b1);
        tick();

        bad_code();
        do_op(MUL, 16'h0102, 16'h0304, 1'b1);
        tick();

        bus.start    = 1'b1;
        bus.alu_ctrl = MUL;
        bus.op_a     = 16'h00AB;
        bus.op_b     = 16'h0102;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_busy", bus.busy, 1'b0);
        check("midrun_done", bus.done, 1'b0);
        check("midrun_hi", bus.result_hi, 16'h0000);
        check("midrun_lo", bus.result_lo, 16'h0000);
        check("midrun_dbz", bus.div_by_zero, 1'b0);
        exp_hi  = '0;
        exp_lo  = '0;
        exp_dbz = 1'b0;
        do_op(MUL, 16'h00AB, 16'h0102, 1'b0);
        tick();

`ifdef MULDIV_SIGNED_EN
        do_op(MUL, 16'hFFFD, 16'h0005, 1'b0);
        check("tp_smul", {bus.result_hi, bus.result_lo}, 32'hFFFF_FFF1);
        do_op(DIV, 16'hFFF9, 16'h0002, 1'b0);
        check("tp_sdiv", {bus.result_hi, bus.result_lo}, 32'hFFFF_FFFD);
        do_op(DIV, 16'h8000, 16'hFFFF, 1'b0);
        check("tp_sdiv_min", {bus.result_hi, bus.result_lo}, 32'h0000_8000);
        tick();
`endif

        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) bad_code();
            else do_op(($urandom_range(0, 1) == 1) ? DIV : MUL,
                       pick(), pick(), r == 1);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle multiply/divide sequencer for the CPU execute stage. The ALU control decode marks mul (4'b0001) and div (4'b0010) as multi-cycle operations. This block accepts those operations, runs an iterative shift-add multiply or restoring divide over WIDTH cycles, and stalls the pipeline while it runs. All other ALU control codes bypass this block.

## Interface

Parameters:
- WIDTH, 16, operand width in bits. Must be ≥ 2. The iteration counter is $clog2(WIDTH+1) bits.

Ports:
- clk  input  1  system clock, rising edge. This is the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe, sampled on the rising edge of clk.
- alu_ctrl  input  4  ALU control code from the ALU control decode.
- op_a  input  WIDTH  multiplicand or dividend.
- op_b  input  WIDTH  multiplier or divisor.
- stall  output  1  pipeline hold, combinational: busy | (start & code_ok & idle_or_done).
- busy  output  1  high while in RUN or FIX.
- done  output  1  one-cycle pulse when the results become valid.
- result_hi  output  WIDTH  product high half (mul) or remainder (div).
- result_lo  output  WIDTH  product low half (mul) or quotient (div).
- div_by_zero  output  1  set on the done cycle of a div with op_b == 0.

## Operation

- code_ok is true for alu_ctrl 4'b0001 (mul) and 4'b0010 (div). Any other code is ignored, with no state change.
- Reset (rst = 1 at a clock edge):
  - State goes to IDLE.
  - busy = 0, done = 0, result_hi = 0, result_lo = 0, div_by_zero = 0.
  - The counter is cleared.
  - Reset in any state, including mid-RUN, aborts the operation and discards partial results.
- States: IDLE, RUN, FIX, DONE.
- IDLE: on start & code_ok, latch the operands and the op type, load the counter with WIDTH, and go to RUN.
- RUN: perform one iteration per cycle and decrement the counter. When the counter reaches 1, go to FIX.
  - mul: if the multiplier LSB is 1, add the multiplicand into the high accumulator. Then shift {acc_hi, acc_lo} right by 1, capturing the carry. The accumulator is 2·WIDTH+1 bits wide internally.
  - div (restoring): shift {rem, quo} left by 1, then trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quotient LSB to 1. Otherwise restore rem.
- FIX: apply sign correction (macro only), then write result_hi, result_lo and div_by_zero. Go to DONE.
- DONE: done = 1 for exactly this cycle. Next state:
  - RUN if start & code_ok (back-to-back operations are accepted).
  - IDLE otherwise.
- Results hold their value from FIX until the FIX of the next operation, or until reset.
- start asserted in RUN or FIX is ignored. The requester holds start while stall = 1.
- Divide by zero:
  - The operation runs the full latency.
  - result_lo = all ones, result_hi = op_a, div_by_zero = 1.
- div_by_zero is cleared at the FIX of any operation that is not a divide by zero.

## Timing

- The start is accepted at clock edge E0.
- busy is high in cycles 1 through WIDTH+1: WIDTH cycles of RUN plus 1 cycle of FIX.
- done is high in cycle WIDTH+2 (18 for WIDTH = 16), and busy is 0 in that cycle.
- Results are valid from cycle WIDTH+2 onward.
- Throughput is one operation per WIDTH+2 cycles when requests are issued back-to-back from DONE.
- stall rises combinationally in the cycle the start is accepted. It stays high through FIX and is low in DONE unless a new start is accepted.
- If rst and start are high in the same cycle, rst wins.

## Configuration

- MULDIV_SIGNED_EN defined:
  - Operands are two's complement.
  - IDLE latches the magnitudes |op_a| and |op_b| and the two sign bits.
  - In FIX:
    - The product is negated if sign_a ^ sign_b.
    - The quotient is negated if sign_a ^ sign_b.
    - The remainder takes the sign of op_a (truncating division).
  - Most-negative / -1: quotient = the most-negative value (wraps), remainder = 0.
  - Divide by zero: the quotient stays all ones (-1) and the remainder = op_a.
- MULDIV_SIGNED_EN undefined: operands are unsigned, and FIX only registers the results. No extra latency is added in either build.

## Test plan

- Unsigned mul:
  - 0x0003 × 0x0005 → result_hi = 0x0000, result_lo = 0x000F, done in cycle 18, busy high in cycles 1–17.
  - 0xFFFF × 0xFFFF → result_hi = 0xFFFE, result_lo = 0x0001.
- div 100 / 7 → result_lo = 14, result_hi = 2, div_by_zero = 0. The test then issues a back-to-back div 0x1234 / 0 from the DONE cycle: it must be accepted with no IDLE cycle, and return result_lo = 0xFFFF, result_hi = 0x1234, div_by_zero = 1.
- start with alu_ctrl = 4'b1111 → busy, stall and done stay 0, and the results are unchanged.
- start pulsed in RUN → ignored. The in-flight result still completes in cycle 18.
- rst asserted in RUN cycle 5 → next cycle busy = 0, results = 0, state = IDLE. A new mul issued after that completes normally.
- With MULDIV_SIGNED_EN:
  - −3 × 5 → {hi, lo} = 0xFFFF_FFF1.
  - −7 / 2 → result_lo = 0xFFFD, result_hi = 0xFFFF.
  - 0x8000 / 0xFFFF → result_lo = 0x8000, result_hi = 0x0000.
